// File: rtl/axi3_pkg.sv
// Shared AXI3 types and constants for the memory slave and its helpers.
package axi3_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t BRESP_OKAY   = 2'b00;
  localparam axi_resp_t BRESP_EXOKAY = 2'b01;
  localparam axi_resp_t BRESP_SLVERR = 2'b10;
  localparam axi_resp_t BRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_burst_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  // Merge two responses keeping the higher-priority error (DECERR > SLVERR > OKAY).
  function automatic axi_resp_t resp_max(input axi_resp_t a, input axi_resp_t b);
    axi_resp_t r;
    if ((a == BRESP_DECERR) || (b == BRESP_DECERR)) begin
      r = BRESP_DECERR;
    end else if ((a == BRESP_SLVERR) || (b == BRESP_SLVERR)) begin
      r = BRESP_SLVERR;
    end else begin
      r = BRESP_OKAY;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi3_if.sv
// AXI3 bundle with master and slave views; widths follow the parameters.
interface axi3_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDR_BYTES    = 4,
  parameter int NUM_ID_BITS_P = 4
);

  localparam int DATA_W = DATA_BYTES * 8;
  localparam int ADDR_W = ADDR_BYTES * 8;

  logic [NUM_ID_BITS_P-1:0] awid;
  logic [ADDR_W-1:0]        awaddr;
  logic [3:0]               awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic [1:0]               awlock;
  logic [3:0]               awcache;
  logic [2:0]               awprot;
  logic                     awvalid;
  logic                     awready;

  logic [NUM_ID_BITS_P-1:0] wid;
  logic [DATA_W-1:0]        wdata;
  logic [DATA_BYTES-1:0]    wstrb;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;

  logic [NUM_ID_BITS_P-1:0] bid;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  logic [NUM_ID_BITS_P-1:0] arid;
  logic [ADDR_W-1:0]        araddr;
  logic [3:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic [1:0]               arlock;
  logic [3:0]               arcache;
  logic [2:0]               arprot;
  logic                     arvalid;
  logic                     arready;

  logic [NUM_ID_BITS_P-1:0] rid;
  logic [DATA_W-1:0]        rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi3_burst_addr.sv
// Combinational AXI3 next-beat address generator with burst configuration check.
module axi3_burst_addr
  import axi3_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [3:0]        len,
  input  axi_burst_t        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              bad_cfg
);

  localparam int LOG2_DB = $clog2(DATA_BYTES);
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] sz_s;
  logic [ADDR_W-1:0] bound_s;
  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] wrap_s;
  logic              wrap_len_ok_s;

  // Step the address by transfer size according to burst type.
  always_comb begin
    sz_s    = ONE << size;
    bound_s = sz_s * ({{(ADDR_W-4){1'b0}}, len} + ONE);
    incr_s  = (addr & ~(sz_s - ONE)) + sz_s;
    wrap_s  = (addr & ~(bound_s - ONE)) | ((addr + sz_s) & (bound_s - ONE));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP:  next_addr = wrap_s;
      default:     next_addr = incr_s;
    endcase
  end

  // Flag sizes wider than the bus, illegal wrap lengths and the reserved burst type.
  always_comb begin
    wrap_len_ok_s = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    bad_cfg = (size > 3'(LOG2_DB))
           || ((burst == BURST_WRAP) && !wrap_len_ok_s)
           || (burst == BURST_RSVD);
  end

endmodule

// File: rtl/axi3_mem_slave.sv
// AXI3 slave terminating into an on-chip word memory; independent read and write FSMs.
module axi3_mem_slave
  import axi3_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDR_BYTES    = 4,
  parameter int NUM_ID_BITS_P = 4,
  parameter int MEM_DEPTH     = 1024
) (
  input  logic  aclk,
  input  logic  aresetn,
  axi3_if.slave s_axi
);

  localparam int DATA_W = DATA_BYTES * 8;
  localparam int ADDR_W = ADDR_BYTES * 8;
  localparam int OFF_W  = $clog2(DATA_BYTES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  // ---------------- write path ----------------
  w_state_t                 w_state_r;
  w_state_t                 w_state_nxt_s;
  logic [ADDR_W-1:0]        aw_addr_r;
  logic [3:0]               aw_len_r;
  logic [2:0]               aw_size_r;
  axi_burst_t               aw_burst_r;
  logic [NUM_ID_BITS_P-1:0] aw_id_r;
  logic [3:0]               w_beat_r;
  axi_resp_t                w_err_r;
  logic                     awready_r;
  logic                     wready_r;
  logic                     bvalid_r;
  logic [NUM_ID_BITS_P-1:0] bid_r;
  axi_resp_t                bresp_r;

  logic                     aw_hs_s;
  logic                     w_hs_s;
  logic                     b_hs_s;
  logic [ADDR_W-1:0]        w_next_addr_s;
  logic                     w_bad_cfg_s;
  logic [IDX_W-1:0]         w_idx_s;
  logic                     w_decerr_s;
  logic                     w_last_beat_s;
  logic                     w_proto_err_s;
  axi_resp_t                w_beat_resp_s;
  logic                     w_we_s;

  assign aw_hs_s = s_axi.awvalid & awready_r;
  assign w_hs_s  = s_axi.wvalid & wready_r;
  assign b_hs_s  = bvalid_r & s_axi.bready;

  axi3_burst_addr #(
    .ADDR_W     (ADDR_W),
    .DATA_BYTES (DATA_BYTES)
  ) u_waddr (
    .addr      (aw_addr_r),
    .size      (aw_size_r),
    .len       (aw_len_r),
    .burst     (aw_burst_r),
    .next_addr (w_next_addr_s),
    .bad_cfg   (w_bad_cfg_s)
  );

  // Per-beat write decode: range check, protocol checks and sticky response merge.
  always_comb begin
    w_idx_s       = aw_addr_r[ADDR_W-1:OFF_W];
    w_decerr_s    = (w_idx_s >= IDX_W'(MEM_DEPTH));
    w_last_beat_s = (w_beat_r == aw_len_r);
    w_proto_err_s = w_bad_cfg_s
                 || (s_axi.wlast != w_last_beat_s)
                 || (s_axi.wid != aw_id_r);
    w_beat_resp_s = resp_max(w_err_r,
                             resp_max(w_decerr_s ? BRESP_DECERR : BRESP_OKAY,
                                      w_proto_err_s ? BRESP_SLVERR : BRESP_OKAY));
    w_we_s        = w_hs_s & ~w_decerr_s;
  end

  // Write FSM next-state: burst ends on beat count, not on wlast.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_state_nxt_s = W_DATA;
        end else begin
          w_state_nxt_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s && w_last_beat_s) begin
          w_state_nxt_s = W_RESP;
        end else begin
          w_state_nxt_s = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_nxt_s = W_IDLE;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write FSM state and registered handshake outputs decoded from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= (w_state_nxt_s == W_IDLE);
      wready_r  <= (w_state_nxt_s == W_DATA);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
    end
  end

  // Capture the write command, then advance address, beat count and sticky error per beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_addr_r  <= {ADDR_W{1'b0}};
      aw_len_r   <= 4'd0;
      aw_size_r  <= 3'd0;
      aw_burst_r <= BURST_FIXED;
      aw_id_r    <= {NUM_ID_BITS_P{1'b0}};
      w_beat_r   <= 4'd0;
      w_err_r    <= BRESP_OKAY;
      bresp_r    <= BRESP_OKAY;
      bid_r      <= {NUM_ID_BITS_P{1'b0}};
    end else if (aw_hs_s) begin
      aw_addr_r  <= s_axi.awaddr;
      aw_len_r   <= s_axi.awlen;
      aw_size_r  <= s_axi.awsize;
      aw_burst_r <= axi_burst_t'(s_axi.awburst);
      aw_id_r    <= s_axi.awid;
      w_beat_r   <= 4'd0;
      w_err_r    <= BRESP_OKAY;
    end else if (w_hs_s) begin
      aw_addr_r <= w_next_addr_s;
      w_beat_r  <= w_beat_r + 4'd1;
      w_err_r   <= w_beat_resp_s;
      if (w_last_beat_s) begin
        bresp_r <= w_beat_resp_s;
        bid_r   <= aw_id_r;
      end
    end
  end

  // Byte-enabled memory write port; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (w_we_s && s_axi.wstrb[b]) begin
        mem_r[w_idx_s[MEM_AW-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t                 r_state_r;
  r_state_t                 r_state_nxt_s;
  logic [ADDR_W-1:0]        ar_addr_r;
  logic [3:0]               ar_len_r;
  logic [2:0]               ar_size_r;
  axi_burst_t               ar_burst_r;
  logic [NUM_ID_BITS_P-1:0] ar_id_r;
  logic [3:0]               r_beat_r;
  logic                     arready_r;
  logic                     rvalid_r;
  logic                     rlast_r;
  logic [DATA_W-1:0]        rdata_r;
  axi_resp_t                rresp_r;
  logic [NUM_ID_BITS_P-1:0] rid_r;

  logic                     ar_hs_s;
  logic                     r_hs_s;
  logic [ADDR_W-1:0]        r_next_addr_s;
  logic                     r_bad_cfg_s;
  logic [IDX_W-1:0]         r_idx_s;
  logic                     r_decerr_s;
  logic                     r_last_beat_s;
  axi_resp_t                r_beat_resp_s;

  assign ar_hs_s = s_axi.arvalid & arready_r;
  assign r_hs_s  = rvalid_r & s_axi.rready;

  axi3_burst_addr #(
    .ADDR_W     (ADDR_W),
    .DATA_BYTES (DATA_BYTES)
  ) u_raddr (
    .addr      (ar_addr_r),
    .size      (ar_size_r),
    .len       (ar_len_r),
    .burst     (ar_burst_r),
    .next_addr (r_next_addr_s),
    .bad_cfg   (r_bad_cfg_s)
  );

  // Per-beat read decode: range check and per-beat response.
  always_comb begin
    r_idx_s       = ar_addr_r[ADDR_W-1:OFF_W];
    r_decerr_s    = (r_idx_s >= IDX_W'(MEM_DEPTH));
    r_last_beat_s = (r_beat_r == ar_len_r);
    r_beat_resp_s = resp_max(r_decerr_s ? BRESP_DECERR : BRESP_OKAY,
                             r_bad_cfg_s ? BRESP_SLVERR : BRESP_OKAY);
  end

  // Read FSM next-state: every beat goes through a one-cycle fetch.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_nxt_s = R_FETCH;
        end else begin
          r_state_nxt_s = R_IDLE;
        end
      end
      R_FETCH: r_state_nxt_s = R_DATA;
      R_DATA: begin
        if (r_hs_s && rlast_r) begin
          r_state_nxt_s = R_IDLE;
        end else if (r_hs_s) begin
          r_state_nxt_s = R_FETCH;
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read FSM state and registered handshake outputs decoded from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= (r_state_nxt_s == R_IDLE);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
    end
  end

  // Capture the read command, advance per accepted beat, and load the R payload on fetch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_addr_r  <= {ADDR_W{1'b0}};
      ar_len_r   <= 4'd0;
      ar_size_r  <= 3'd0;
      ar_burst_r <= BURST_FIXED;
      ar_id_r    <= {NUM_ID_BITS_P{1'b0}};
      r_beat_r   <= 4'd0;
      rdata_r    <= {DATA_W{1'b0}};
      rresp_r    <= BRESP_OKAY;
      rlast_r    <= 1'b0;
      rid_r      <= {NUM_ID_BITS_P{1'b0}};
    end else begin
      if (ar_hs_s) begin
        ar_addr_r  <= s_axi.araddr;
        ar_len_r   <= s_axi.arlen;
        ar_size_r  <= s_axi.arsize;
        ar_burst_r <= axi_burst_t'(s_axi.arburst);
        ar_id_r    <= s_axi.arid;
        r_beat_r   <= 4'd0;
      end else if (r_hs_s) begin
        ar_addr_r <= r_next_addr_s;
        r_beat_r  <= r_beat_r + 4'd1;
      end
      if (r_state_r == R_FETCH) begin
        rdata_r <= r_decerr_s ? {DATA_W{1'b0}} : mem_r[r_idx_s[MEM_AW-1:0]];
        rresp_r <= r_beat_resp_s;
        rlast_r <= r_last_beat_s;
        rid_r   <= ar_id_r;
      end
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bid     = bid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rlast   = rlast_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rid     = rid_r;

  // Lock, cache and protection attributes have no effect on this memory.
  logic unused_attr_s;
  assign unused_attr_s = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                           s_axi.arlock, s_axi.arcache, s_axi.arprot};

endmodule

// File: tb/tb_axi3_mem_slave.sv
// Directed self-checking bench for axi3_mem_slave.
module tb_axi3_mem_slave;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  axi3_if #(.DATA_BYTES(4), .ADDR_BYTES(4), .NUM_ID_BITS_P(4)) bus ();

  axi3_mem_slave #(
    .DATA_BYTES    (4),
    .ADDR_BYTES    (4),
    .NUM_ID_BITS_P (4),
    .MEM_DEPTH     (1024)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n;
    n = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    chk("aw_ready_wait", 32'(bus.awready), 32'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] id);
    int n;
    n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wid = id; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    chk("w_ready_wait", 32'(bus.wready), 32'd1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'(resp));
    chk({tag, "_bid"}, 32'(bus.bid), 32'(id));
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n;
    n = 0;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    chk("ar_ready_wait", 32'(bus.arready), 32'd1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic r_recv(input string tag, input logic [31:0] data, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    int n;
    n = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, "_rdata"}, bus.rdata, data);
    chk({tag, "_rresp"}, 32'(bus.rresp), 32'(resp));
    chk({tag, "_rlast"}, 32'(bus.rlast), 32'(last));
    chk({tag, "_rid"}, 32'(bus.rid), 32'(id));
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    aresetn = 1'b0;
    bus.awid = 4'd0; bus.awaddr = 32'd0; bus.awlen = 4'd0; bus.awsize = 3'd2; bus.awburst = 2'd1;
    bus.awlock = 2'd0; bus.awcache = 4'd0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
    bus.wid = 4'd0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 4'd0; bus.arsize = 3'd2; bus.arburst = 2'd1;
    bus.arlock = 2'd0; bus.arcache = 4'd0; bus.arprot = 3'd0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_bid",     32'(bus.bid),     32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_rid",     32'(bus.rid),     32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    aresetn = 1'b1;
    chk("rel_awready_pre", 32'(bus.awready), 32'd0);
    @(posedge aclk); #1;
    chk("rel_awready", 32'(bus.awready), 32'd1);
    chk("rel_arready", 32'(bus.arready), 32'd1);

    // INCR write len=3 at 0x10, with handshake timing checks
    aw_send(32'h10, 4'd3, 3'd2, 2'd1, 4'd5);
    chk("incr_wready_n1", 32'(bus.wready), 32'd1);
    chk("incr_awready_low", 32'(bus.awready), 32'd0);
    w_send(32'hA0, 4'hF, 1'b0, 4'd5);
    w_send(32'hA1, 4'hF, 1'b0, 4'd5);
    w_send(32'hA2, 4'hF, 1'b0, 4'd5);
    chk("incr_bvalid_early", 32'(bus.bvalid), 32'd0);
    w_send(32'hA3, 4'hF, 1'b1, 4'd5);
    chk("incr_bvalid_m1", 32'(bus.bvalid), 32'd1);
    b_recv("incr_b", 2'd0, 4'd5);

    // INCR read back, first rvalid two edges after AR
    ar_send(32'h10, 4'd3, 3'd2, 2'd1, 4'd6);
    chk("incr_rvalid_n1", 32'(bus.rvalid), 32'd0);
    @(posedge aclk); #1;
    chk("incr_rvalid_n2", 32'(bus.rvalid), 32'd1);
    r_recv("incr_r0", 32'hA0, 2'd0, 1'b0, 4'd6);
    chk("incr_rvalid_gap", 32'(bus.rvalid), 32'd0);
    r_recv("incr_r1", 32'hA1, 2'd0, 1'b0, 4'd6);
    r_recv("incr_r2", 32'hA2, 2'd0, 1'b0, 4'd6);
    r_recv("incr_r3", 32'hA3, 2'd0, 1'b1, 4'd6);

    // Preload words 0..3 with their own index, then WRAP read from 0x08
    aw_send(32'h0, 4'd3, 3'd2, 2'd1, 4'd1);
    w_send(32'd0, 4'hF, 1'b0, 4'd1);
    w_send(32'd1, 4'hF, 1'b0, 4'd1);
    w_send(32'd2, 4'hF, 1'b0, 4'd1);
    w_send(32'd3, 4'hF, 1'b1, 4'd1);
    b_recv("pre_b", 2'd0, 4'd1);
    ar_send(32'h08, 4'd3, 3'd2, 2'd2, 4'd2);
    r_recv("wrap_r0", 32'd2, 2'd0, 1'b0, 4'd2);
    r_recv("wrap_r1", 32'd3, 2'd0, 1'b0, 4'd2);
    r_recv("wrap_r2", 32'd0, 2'd0, 1'b0, 4'd2);
    r_recv("wrap_r3", 32'd1, 2'd0, 1'b1, 4'd2);

    // FIXED write len=2 to 0x20 merging byte lanes into word 8
    aw_send(32'h20, 4'd2, 3'd2, 2'd0, 4'd2);
    w_send(32'h1111_1111, 4'h1, 1'b0, 4'd2);
    w_send(32'h2222_2222, 4'h2, 1'b0, 4'd2);
    w_send(32'h3333_3333, 4'hC, 1'b1, 4'd2);
    b_recv("fixed_b", 2'd0, 4'd2);
    ar_send(32'h20, 4'd0, 3'd2, 2'd0, 4'd3);
    r_recv("fixed_r", 32'h3333_2211, 2'd0, 1'b1, 4'd3);

    // Out-of-range write: DECERR and no aliasing onto word 0
    aw_send(32'h1000, 4'd0, 3'd2, 2'd1, 4'd4);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1, 4'd4);
    b_recv("decerr_b", 2'd3, 4'd4);
    ar_send(32'h0, 4'd0, 3'd2, 2'd1, 4'd4);
    r_recv("decerr_w0", 32'd0, 2'd0, 1'b1, 4'd4);
    ar_send(32'h1000, 4'd0, 3'd2, 2'd1, 4'd9);
    r_recv("decerr_r", 32'd0, 2'd3, 1'b1, 4'd9);
    ar_send(32'h10, 4'd0, 3'd2, 2'd3, 4'd9);
    r_recv("rsvd_r", 32'hA0, 2'd2, 1'b1, 4'd9);

    // Early wlast on beat 1 of len=3: all four beats taken, SLVERR
    aw_send(32'h40, 4'd3, 3'd2, 2'd1, 4'd7);
    w_send(32'hB0, 4'hF, 1'b0, 4'd7);
    w_send(32'hB1, 4'hF, 1'b1, 4'd7);
    chk("early_wready_held", 32'(bus.wready), 32'd1);
    chk("early_bvalid_low", 32'(bus.bvalid), 32'd0);
    w_send(32'hB2, 4'hF, 1'b0, 4'd7);
    w_send(32'hB3, 4'hF, 1'b0, 4'd7);
    b_recv("early_b", 2'd2, 4'd7);

    // Backpressure: B and R held with bready=rready=0 for 5 cycles
    aw_send(32'h50, 4'd0, 3'd2, 2'd1, 4'd3);
    w_send(32'hC0, 4'hF, 1'b1, 4'd3);
    ar_send(32'h10, 4'd1, 3'd2, 2'd1, 4'd7);
    @(posedge aclk); #1;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid",  32'(bus.bvalid),  32'd1);
      chk("stall_bid",     32'(bus.bid),     32'd3);
      chk("stall_bresp",   32'(bus.bresp),   32'd0);
      chk("stall_rvalid",  32'(bus.rvalid),  32'd1);
      chk("stall_rdata",   bus.rdata,        32'hA0);
      chk("stall_rid",     32'(bus.rid),     32'd7);
      chk("stall_rlast",   32'(bus.rlast),   32'd0);
      chk("stall_awready", 32'(bus.awready), 32'd0);
      chk("stall_arready", 32'(bus.arready), 32'd0);
      @(posedge aclk); #1;
    end
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    b_recv("stall_b", 2'd0, 4'd3);
    r_recv("stall_r0", 32'hA0, 2'd0, 1'b0, 4'd7);
    r_recv("stall_r1", 32'hA1, 2'd0, 1'b1, 4'd7);

    // Reset while beat 2 of a read is pending, then a clean burst
    ar_send(32'h10, 4'd3, 3'd2, 2'd1, 4'd8);
    r_recv("mid_r0", 32'hA0, 2'd0, 1'b0, 4'd8);
    r_recv("mid_r1", 32'hA1, 2'd0, 1'b0, 4'd8);
    @(posedge aclk); #1;
    chk("mid_beat2_pending", 32'(bus.rvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("mid_rst_arready", 32'(bus.arready), 32'd0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("mid_rel_arready", 32'(bus.arready), 32'd1);
    ar_send(32'h40, 4'd3, 3'd2, 2'd1, 4'd1);
    r_recv("post_r0", 32'hB0, 2'd0, 1'b0, 4'd1);
    r_recv("post_r1", 32'hB1, 2'd0, 1'b0, 4'd1);
    r_recv("post_r2", 32'hB2, 2'd0, 1'b0, 4'd1);
    r_recv("post_r3", 32'hB3, 2'd0, 1'b1, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi3_mem_slave.md
# axi3_mem_slave

AXI3 slave that terminates an `axi3_if` slave modport into a single-clock on-chip word memory. It supports FIXED, INCR and WRAP bursts of up to 16 beats with byte strobes and independent read and write paths. It sits directly downstream of the interface as the default memory endpoint for masters and testbenches.

## Interface
- `DATA_BYTES`, 4, bus width in bytes (power of 2).
- `ADDR_BYTES`, 4, address width in bytes.
- `NUM_ID_BITS_P`, 4, ID width.
- `MEM_DEPTH`, 1024, memory depth in `DATA_BYTES`-wide words.

- `aclk`  input  1  clock; all logic is on the rising edge.
- `aresetn`  input  1  reset, asynchronous assert, active-low.
- `s_axi`  `axi3_if.slave` modport  —  all AXI3 channels, with widths set by the interface parameters (which must match this block's).

## Operation
- **Reset values:** `awready`, `wready`, `bvalid`, `arready`, `rvalid` and `rlast` are 0; `bresp`, `bid`, `rresp`, `rid` and `rdata` are 0. Memory contents are not reset.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: `awready`=1. On an AW handshake, capture addr, len, size, burst and id; clear the beat counter and error flags.
  - W_DATA: `wready`=1. Each W handshake writes the lanes with `wstrb`=1 to word `addr>>log2(DATA_BYTES)`, then advances the address and beat count.
  - Leave W_DATA after beat `awlen`. Termination uses the beat count; `wlast` does not end the burst.
  - W_RESP: `bvalid`=1, `bid`=captured id. Hold until `bready`.
- **Read FSM: R_IDLE → R_FETCH → R_DATA → (R_FETCH | R_IDLE).**
  - R_IDLE: `arready`=1.
  - R_FETCH: one-cycle synchronous memory read.
  - R_DATA: `rvalid`=1, with `rdata`, `rid`, `rresp` and `rlast` (=final beat) held stable until `rready`.
- **Address step:** `sz = 1<<size`.
  - FIXED: the address does not change.
  - INCR: `addr = (addr & ~(sz-1)) + sz`.
  - WRAP: boundary `B = sz*(len+1)`; `addr = (addr & ~(B-1)) | ((addr+sz) & (B-1))`.
  - Burst type 3 steps as INCR and flags SLVERR. 4 KB crossings are not checked.
- **Errors** (priority DECERR > SLVERR > OKAY):
  - DECERR: word index ≥ `MEM_DEPTH` on any beat. That beat's write is suppressed; that read beat returns `rdata`=0.
  - SLVERR, either channel: `size > log2(DATA_BYTES)`; WRAP with len not in {1,3,7,15}; burst type 3.
  - SLVERR, write only: `wlast` value differs from (beat==len), or `wid`≠`awid`.
  - A write has one sticky `bresp` for the whole burst. Reads report `rresp` per beat.
- **Locking:** `awlock`/`arlock` are ignored; exclusive access is never granted (no EXOKAY).
- **Write/read collision:** a write and a read to the same word in the same cycle gives read-before-write, so the read returns the old data.
- **Reset mid-burst:** both FSMs return to IDLE immediately and the partial burst is discarded. Memory keeps any beats already written.

## Timing
- AW handshake at edge N: `wready` is high from N+1.
- Last W beat at edge M: `bvalid` is high from M+1.
- AR handshake at edge N: first `rvalid` at N+2.
  - Each later beat's `rvalid` comes 2 cycles after the previous R handshake.
  - Peak read throughput is one beat per 2 cycles.
- `awready`/`arready` rise on the first edge after reset release. They are low outside IDLE, so only one outstanding transaction per direction.
- Write and read FSMs run concurrently and independently.
- `cache`/`prot` inputs are ignored.

## Structure
- Package `axi3_pkg` holds:
  - `BRESP_*` and `BURST_*` constants;
  - `axi_burst_t` (2-bit enum);
  - `axi_resp_t`;
  - function `resp_max(a,b)` for error-priority merge.
- Sub-module `axi3_burst_addr` (combinational): inputs addr, size, len, burst; outputs next_addr and `bad_cfg`. Instantiated twice, once for write and once for read.
- The memory is a single inferred array with a byte-enable write port and a synchronous read port.

## Test plan
- INCR write, len=3, size=2, addr 0x10, data 0xA0..0xA3, strb 0xF → `bresp`=0. A read of the same burst returns 0xA0..0xA3 with `rlast` on beat 3 only and `rresp`=0.
- WRAP read, len=3, size=2, addr 0x08, memory preloaded at word k = k → data 2,3,0,1.
- FIXED write, len=2, addr 0x20, strb 0x1 then 0x2 then 0xC → word 8 = merged bytes; `bresp`=OKAY.
- Write to word `MEM_DEPTH` → `bresp`=3 and no memory change. Write with early `wlast` on beat 1 of len=3 → all 4 beats are accepted and `bresp`=2.
- With `bready`=0 and `rready`=0 held 5 cycles → `bvalid`/`rvalid` and payload stay stable, and no new AW/AR is accepted.
- Assert `aresetn`=0 mid-read on beat 2 → `rvalid`=0 and `arready`=0 immediately. After release `arready`=1 on the next edge, and a new burst completes normally.
